// File: rtl/me_pkg.sv
// Shared types and constants for the block-matching motion estimator controller.
package me_pkg;
  localparam int RMEM_MAX         = 256;
  localparam int SMEM_MAX         = 961;
  localparam int BLOCK_SIZE_DEF   = 16;
  localparam int SEARCH_WIDTH_DEF = 31;
  localparam int SAD_W            = 16;
  localparam int RA_W             = $clog2(RMEM_MAX);
  localparam int SA_W             = $clog2(SMEM_MAX);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CMP, DONE} me_state_e;

  function automatic logic [7:0] sat8(input logic [SAD_W-1:0] v);
    return (|v[SAD_W-1:8]) ? 8'hFF : v[7:0];
  endfunction
endpackage

// File: rtl/me_addr_gen.sv
// Scan counters for the full search; emits one registered address beat per step.
module me_addr_gen
  import me_pkg::*;
#(
  parameter int BLOCK_SIZE   = BLOCK_SIZE_DEF,
  parameter int SEARCH_WIDTH = SEARCH_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            init,
  input  logic            step,
  output logic [RA_W-1:0] addr_r,
  output logic [SA_W-1:0] addr_s1,
  output logic [SA_W-1:0] addr_s2,
  output logic            beat_vld,
  output logic            first,
  output logic            last,
  output logic            at_end
);
  localparam int CW = $clog2(BLOCK_SIZE);
  localparam int PW = $clog2(BLOCK_SIZE/2);
  localparam logic [CW-1:0]   CMAX    = CW'(BLOCK_SIZE-1);
  localparam logic [PW-1:0]   PMAX    = PW'(BLOCK_SIZE/2-1);
  localparam logic [CW-1:0]   C_ONE   = CW'(1);
  localparam logic [PW-1:0]   P_ONE   = PW'(1);
  localparam logic [RA_W-1:0] R_ONE   = RA_W'(1);
  localparam logic [SA_W-1:0] S_ONE   = SA_W'(1);
  localparam logic [SA_W-1:0] S_TWO   = SA_W'(2);
  localparam logic [SA_W-1:0] PITCH   = SA_W'(SEARCH_WIDTH);
  // From dy*W + (B-2) (last pair of a row of candidates) to (dy+1)*W.
  localparam logic [SA_W-1:0] DY_STEP = SA_W'(SEARCH_WIDTH - (BLOCK_SIZE-2));

  logic [CW-1:0]   c, r, dy;
  logic [PW-1:0]   dxp;
  logic [RA_W-1:0] r_cnt;
  logic [SA_W-1:0] pair_base, row_base, next_pair_base, s_cur;
  logic            row_end, pair_end;

  assign row_end        = (c == CMAX);
  assign pair_end       = row_end && (r == CMAX);
  assign at_end         = pair_end && (dxp == PMAX) && (dy == CMAX);
  assign next_pair_base = (dxp == PMAX) ? pair_base + DY_STEP : pair_base + S_TWO;
  assign s_cur          = row_base + SA_W'(c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c <= '0; r <= '0; dy <= '0; dxp <= '0; r_cnt <= '0;
      pair_base <= '0; row_base <= '0;
      addr_r <= '0; addr_s1 <= '0; addr_s2 <= '0;
      beat_vld <= 1'b0; first <= 1'b0; last <= 1'b0;
    end else if (init) begin
      c <= '0; r <= '0; dy <= '0; dxp <= '0; r_cnt <= '0;
      pair_base <= '0; row_base <= '0;
      beat_vld <= 1'b0;
    end else begin
      beat_vld <= step;
      if (step) begin
        addr_r  <= r_cnt;
        addr_s1 <= s_cur;
        addr_s2 <= s_cur + S_ONE;
        first   <= (c == '0) && (r == '0);
        last    <= pair_end;
        c       <= row_end ? '0 : c + C_ONE;
        r_cnt   <= pair_end ? '0 : r_cnt + R_ONE;
        if (pair_end) begin
          r         <= '0;
          dxp       <= (dxp == PMAX) ? '0 : dxp + P_ONE;
          if (dxp == PMAX) dy <= dy + C_ONE;
          pair_base <= next_pair_base;
          row_base  <= next_pair_base;
        end else if (row_end) begin
          r        <= r + C_ONE;
          row_base <= row_base + PITCH;
        end
      end
    end
  end
endmodule

// File: rtl/motion_estimator_controller.sv
// Full-search sequencer FSM, accumulator strobes and best-match tracker for a
// two-lane SAD datapath.
module motion_estimator_controller
  import me_pkg::*;
#(
  parameter int BLOCK_SIZE   = BLOCK_SIZE_DEF,
  parameter int SEARCH_WIDTH = SEARCH_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  output logic [RA_W-1:0]               AddressR,
  output logic [SA_W-1:0]               AddressS1,
  output logic [SA_W-1:0]               AddressS2,
  output logic                          accClear,
  output logic                          accEnable,
  input  logic [SAD_W-1:0]              sad1,
  input  logic [SAD_W-1:0]              sad2,
  output logic [7:0]                    bestDistance,
  output logic [$clog2(BLOCK_SIZE)-1:0] motionX,
  output logic [$clog2(BLOCK_SIZE)-1:0] motionY,
  output logic                          completed
);
  localparam int CW = $clog2(BLOCK_SIZE);
  localparam int PW = $clog2(BLOCK_SIZE/2);
  localparam logic [CW-1:0]    MSB    = {1'b1, {(CW-1){1'b0}}};
  localparam logic [PW+CW-1:0] PR_ONE = (PW+CW)'(1);

  me_state_e         state;
  logic              drain_cnt;
  logic [1:0]        last_pipe;
  logic [SAD_W-1:0]  best, b1, nb;
  logic [CW-1:0]     bx, by, x1, nx, ny, dx_c, dy_c;
  logic [PW+CW-1:0]  cmp_pair;
  logic              accept, beat_vld, first, last, at_end, cmp_strobe;

  assign accept     = start && (state == IDLE || state == DONE);
  assign cmp_strobe = last_pipe[1];
  assign dy_c       = cmp_pair[PW+CW-1:PW];
  assign dx_c       = {cmp_pair[PW-1:0], 1'b0};

  me_addr_gen #(.BLOCK_SIZE(BLOCK_SIZE), .SEARCH_WIDTH(SEARCH_WIDTH)) u_addr (
    .clk(clk), .reset_n(reset_n), .init(accept), .step(state == RUN),
    .addr_r(AddressR), .addr_s1(AddressS1), .addr_s2(AddressS2),
    .beat_vld(beat_vld), .first(first), .last(last), .at_end(at_end)
  );

  // Lane 1 is tested first and both use strict less-than, so earlier scan order wins ties.
  always_comb begin
    b1 = best; x1 = bx;
    nb = best; nx = bx; ny = by;
    if (cmp_strobe) begin
      if (sad1 < best) begin
        b1 = sad1; x1 = dx_c;
      end
      nb = b1; nx = x1;
      if (sad1 < best) ny = dy_c;
      if (sad2 < b1) begin
        nb = sad2; nx = dx_c | CW'(1); ny = dy_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      drain_cnt    <= 1'b0;
      accEnable    <= 1'b0;
      accClear     <= 1'b0;
      last_pipe    <= '0;
      best         <= '1;
      bx           <= '0;
      by           <= '0;
      cmp_pair     <= '0;
      completed    <= 1'b0;
      bestDistance <= 8'hFF;
      motionX      <= '0;
      motionY      <= '0;
    end else begin
      accEnable <= beat_vld;
      accClear  <= beat_vld && first;
      last_pipe <= {last_pipe[0], beat_vld && last};
      if (cmp_strobe) begin
        best     <= nb;
        bx       <= nx;
        by       <= ny;
        cmp_pair <= cmp_pair + PR_ONE;
      end
      case (state)
        IDLE, DONE: if (start) begin
          state     <= RUN;
          best      <= '1;
          bx        <= '0;
          by        <= '0;
          cmp_pair  <= '0;
          completed <= 1'b0;
        end
        RUN: begin
          drain_cnt <= 1'b0;
          if (at_end) state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= CMP;
        end
        CMP: begin
          state        <= DONE;
          completed    <= 1'b1;
          bestDistance <= sat8(nb);
          motionX      <= nx ^ MSB;
          motionY      <= ny ^ MSB;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_motion_estimator_controller.sv
// Bench: memories + two-lane SAD datapath around the controller, checked every
// cycle against an arithmetic model of the scan and an exhaustive search.
module tb_motion_estimator_controller;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [7:0]  AddressR;
  logic [9:0]  AddressS1, AddressS2;
  logic        accClear, accEnable, completed;
  logic [15:0] sad1 = '0, sad2 = '0;
  logic [7:0]  bestDistance;
  logic [3:0]  motionX, motionY;

  logic [7:0]  rmem [256];
  logic [7:0]  smem [961];
  logic [7:0]  rd = '0, s1d = '0, s2d = '0;

  int tests = 0, fails = 0;
  int cyc = 0, t0 = 0;
  bit active = 1'b0;
  int exp_bd = 0, exp_mx = 0, exp_my = 0;

  always #5 clk = ~clk;

  motion_estimator_controller dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
    .accClear(accClear), .accEnable(accEnable),
    .sad1(sad1), .sad2(sad2),
    .bestDistance(bestDistance), .motionX(motionX), .motionY(motionY),
    .completed(completed)
  );

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Synchronous 1-cycle memories and lane accumulators.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd  <= rmem[AddressR];
    s1d <= smem[AddressS1];
    s2d <= smem[AddressS2];
    if (accEnable) begin
      sad1 <= (accClear ? 16'd0 : sad1) + 16'(absd(int'(rd), int'(s1d)));
      sad2 <= (accClear ? 16'd0 : sad2) + 16'(absd(int'(rd), int'(s2d)));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Exhaustive search in scan order; strict < keeps the first minimum.
  task automatic model_search();
    int best, bx, by, s;
    best = 'hFFFF; bx = 0; by = 0;
    for (int dy = 0; dy < 16; dy++)
      for (int dx = 0; dx < 16; dx++) begin
        s = 0;
        for (int r = 0; r < 16; r++)
          for (int c = 0; c < 16; c++)
            s += absd(int'(rmem[r*16+c]), int'(smem[(dy+r)*31+dx+c]));
        if (s < best) begin best = s; bx = dx; by = dy; end
      end
    exp_bd = (best > 255) ? 255 : best;
    exp_mx = bx ^ 8;
    exp_my = by ^ 8;
  endtask

  // Per-cycle compare: n is the number of clock edges since the start edge.
  always @(negedge clk) begin
    int n, k, p, w;
    if (active) begin
      n = cyc - t0 - 1;
      if (n >= 0) begin
        if (n >= 1 && n <= 32768) begin
          k = n - 1; p = k / 256; w = k % 256;
          chk("addr_r", 32'(AddressR), w);
          chk("addr_s1", 32'(AddressS1), (p/8 + w/16)*31 + (p%8)*2 + w%16);
          chk("addr_s2", 32'(AddressS2), (p/8 + w/16)*31 + (p%8)*2 + w%16 + 1);
        end
        chk("acc_enable", 32'(accEnable), 32'(n >= 2 && n <= 32769));
        chk("acc_clear", 32'(accClear), 32'(n >= 2 && n <= 32769 && (n-2) % 256 == 0));
        chk("completed", 32'(completed), 32'(n >= 32771));
        if (n >= 32771) begin
          chk("best_distance", 32'(bestDistance), exp_bd);
          chk("motion_x", 32'(motionX), exp_mx);
          chk("motion_y", 32'(motionY), exp_my);
        end
        if (n == 1) begin
          chk("beat0_r", 32'(AddressR), 0); chk("beat0_s1", 32'(AddressS1), 0);
          chk("beat0_s2", 32'(AddressS2), 1);
        end
        if (n == 3) begin
          chk("beat2_r", 32'(AddressR), 2); chk("beat2_s1", 32'(AddressS1), 2);
          chk("beat2_s2", 32'(AddressS2), 3);
        end
        if (n == 257) begin
          chk("beat256_r", 32'(AddressR), 0); chk("beat256_s1", 32'(AddressS1), 2);
          chk("beat256_s2", 32'(AddressS2), 3);
        end
        if (n == 258) chk("beat256_clear", 32'(accClear), 1);
        if (n == 32768) begin
          chk("beat_last_r", 32'(AddressR), 255); chk("beat_last_s1", 32'(AddressS1), 959);
          chk("beat_last_s2", 32'(AddressS2), 960);
        end
      end
    end else if (reset_n) begin
      chk("idle_acc_enable", 32'(accEnable), 0);
      chk("idle_acc_clear", 32'(accClear), 0);
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_addr_r"}, 32'(AddressR), 0);
    chk({tag, "_addr_s1"}, 32'(AddressS1), 0);
    chk({tag, "_addr_s2"}, 32'(AddressS2), 0);
    chk({tag, "_acc"}, 32'({accClear, accEnable}), 0);
    chk({tag, "_completed"}, 32'(completed), 0);
    chk({tag, "_best_distance"}, 32'(bestDistance), 32'hFF);
    chk({tag, "_motion"}, 32'({motionX, motionY}), 0);
  endtask

  task automatic start_run();
    @(negedge clk);
    t0 = cyc; active = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_n(input int target);
    bit reached = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (cyc - t0 - 1 >= target) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    chk("wait_bound", 32'(reached), 1);
  endtask

  initial begin
    foreach (rmem[i]) rmem[i] = 8'($urandom);
    foreach (smem[i]) smem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_addr", 32'({AddressR, AddressS1, AddressS2}), 0);
    chk("idle_completed", 32'(completed), 0);

    // Abort run: stray start mid-scan is ignored, reset kills it.
    start_run();
    wait_n(500);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_n(1000);
    @(posedge clk);
    #2 active = 1'b0; reset_n = 1'b0;
    #1 check_reset("abort");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Random search window with the reference block embedded at dx=11, dy=6.
    foreach (rmem[i]) rmem[i] = 8'($urandom);
    foreach (smem[i]) smem[i] = 8'($urandom);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) smem[(6+r)*31 + 11 + c] = rmem[r*16+c];
    model_search();
    start_run();
    wait_n(32776);
    active = 1'b0;
    chk("embed_completed", 32'(completed), 1);
    chk("embed_motion_x", 32'(motionX), 32'h3);
    chk("embed_motion_y", 32'(motionY), 32'hE);
    chk("embed_best_distance", 32'(bestDistance), 0);

    // Saturated, all-equal SADs: tie rule picks index 0, distance clips to 255.
    foreach (rmem[i]) rmem[i] = 8'hFF;
    foreach (smem[i]) smem[i] = 8'h00;
    model_search();
    start_run();
    wait_n(32776);
    active = 1'b0;
    chk("sat_completed", 32'(completed), 1);
    chk("sat_motion_x", 32'(motionX), 32'h8);
    chk("sat_motion_y", 32'(motionY), 32'h8);
    chk("sat_best_distance", 32'(bestDistance), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/motion_estimator_controller.md
# motion_estimator_controller

Sequencer and best-match tracker for the full-search block-matching motion estimator. Generates reference/search memory addresses and accumulator strobes for a two-lane SAD datapath (lane 1 = even horizontal candidate on S1, lane 2 = odd candidate on S2). It then compares the returned SADs and reports the best displacement on `motionX`/`motionY`/`bestDistance` with `completed`. It sits between the testbench-visible estimator interface signals and the PE/accumulator datapath.

## Interface
- `BLOCK_SIZE`, default 16: reference block edge in pixels; also the number of candidate positions per axis.
- `SEARCH_WIDTH`, default 31: search-memory row pitch in pixels (BLOCK_SIZE*2-1).
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE or DONE.
- `AddressR`  out  8  reference memory address, r*16+c.
- `AddressS1`  out  10  search address, lane 1 candidate.
- `AddressS2`  out  10  search address, lane 2 candidate (AddressS1+1).
- `accClear`  out  1  first data beat of a candidate pair; datapath loads instead of adds.
- `accEnable`  out  1  R/S1/S2 data valid this cycle.
- `sad1`, `sad2`  in  16 each  lane accumulators, registered in the datapath.
- `bestDistance`  out  8  best SAD, saturated to 255.
- `motionX`, `motionY`  out  4 each  best displacement, two's complement, range -8..+7.
- `completed`  out  1  result valid; held until the next accepted start.

## Operation
- States:
  - IDLE: start → RUN.
  - RUN: issues 32768 address beats, then → DRAIN.
  - DRAIN: 2 cycles for memory latency plus final accumulate → CMP.
  - CMP: final compare → DONE.
  - DONE: start → RUN; otherwise hold.
- Scan order:
  - dy 0..15 (outer), dx 0,2,…,14 (inner; the pair is dx and dx+1).
  - Per pair: row r 0..15 (outer), column c 0..15 (inner).
  - 128 pairs × 256 beats.
- Addresses:
  - AddressR = r*16+c.
  - AddressS1 = (dy+r)*31 + dx + c.
  - AddressS2 = AddressS1+1.
  - Maximum AddressS2 = 960.
  - Addresses are generated with incremental adders; no multipliers.
- Memories are synchronous with 1-cycle read latency. accEnable/accClear are the address-valid/first-beat flags delayed one cycle.
- Compare: in the cycle after a pair's last accEnable, sad1 and then sad2 are compared against the running best.
  - Update only on strict less-than, so the first candidate in scan order wins ties, and lane 1 beats lane 2.
  - Comparison of the next pair overlaps the next pair's address streaming; there are no bubbles.
- On a new accepted start: running best initialised to 16'hFFFF, motion to index 0, completed cleared.
- Motion encoding: index i maps to displacement i-8, i.e. motionX = dx ^ 4'b1000, and likewise for motionY.
- bestDistance = (best > 255) ? 255 : best[7:0].
- start in RUN/DRAIN/CMP is ignored.
- Reset mid-operation aborts immediately and returns to IDLE; there are no partial results.

## Timing
- Reset values:
  - AddressR, AddressS1, AddressS2: 0.
  - accClear, accEnable: 0.
  - completed: 0.
  - bestDistance: 8'hFF.
  - motionX, motionY: 0.
- Edge 0 samples start. Address beat k (0-based) is driven after edge k+1; accEnable for beat k is high after edge k+2.
- Last address beat is after edge 32768. Last accEnable is after edge 32769. Final SADs are valid after edge 32770.
- CMP registers the result at edge 32771; completed, bestDistance and motion outputs update together after edge 32771.
- Latency start→completed: 32771 cycles. Outputs are stable while completed=1.

## Structure
- Shared package `me_pkg`:
  - RMEM_MAX=256, SMEM_MAX=961.
  - BLOCK_SIZE/SEARCH_WIDTH defaults.
  - State enum typedef {IDLE, RUN, DRAIN, CMP, DONE}.
  - SAD width constant (16).
- Sub-module `me_addr_gen`: r/c/dx/dy counters with incremental row-base adders. Outputs the three addresses plus first-beat and last-beat flags; the top level holds the FSM, delay stage and comparator.

## Test plan
- Reset with start held low → all outputs at reset values. Release reset, wait 100 cycles → no address or accEnable activity.
- Address trace:
  - Beats 0,1,2 → R=0,1,2; S1=0,1,2; S2=1,2,3.
  - Beat 256 → R=0, S1=2, S2=3, with accClear asserted one cycle later.
  - Beat 32767 → R=255, S1=959, S2=960.
- Search memory is random with the reference block embedded exactly at dx=11, dy=6 → completed exactly 32771 cycles after start, motionX=4'b0011 (+3), motionY=4'b1110 (-2), bestDistance=0.
- All memories constant 8'h40 → every SAD is 0 → tie rule gives motionX=4'b1000, motionY=4'b1000 (-8,-8), bestDistance=0.
- Saturation: R all 8'hFF, S all 8'h00 → SAD 65280 everywhere → bestDistance=255, motion (-8,-8).
- Start pulsed again at cycle 500 → ignored; reset_n low at cycle 1000 → immediate reset values. Then start → correct result after 32771 cycles.
